// File: rtl/bird_physics.sv
`default_nettype none
// ============================================================================
//  Module      : bird_physics
//  Description : Per-frame vertical physics for the bird sprite. On each
//                enabled frame tick it applies gravity or a flap impulse,
//                integrates a Q10.4 position, clamps at ceiling and ground,
//                then writes the integer row into the display's Y-low and
//                Y-high byte registers as an Avalon-MM write master.
//  Revision    : 1.0 - initial release
// ============================================================================
module bird_physics #(
    parameter int GRAVITY  = 6,
    parameter int FLAP_VEL = -64,
    parameter int VEL_MAX  = 128,
    parameter int Y_START  = 240,
    parameter int Y_MIN    = 0,
    parameter int Y_MAX    = 470,
    parameter int REG_Y_LO = 5,
    parameter int REG_Y_HI = 6
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       frame_tick,
    input  logic       flap,
    input  logic       restart,
    input  logic       enable,
    input  logic       av_waitrequest,
    output logic       av_chipselect,
    output logic       av_write,
    output logic [2:0] av_address,
    output logic [7:0] av_writedata,
    output logic [9:0] bird_y,
    output logic [9:0] bird_vel,
    output logic       dead,
    output logic       update_done,
    output logic       overrun
);

    localparam logic [1:0] C_ST_IDLE   = 2'd0;
    localparam logic [1:0] C_ST_UPDATE = 2'd1;
    localparam logic [1:0] C_ST_WR_LO  = 2'd2;
    localparam logic [1:0] C_ST_WR_HI  = 2'd3;

    localparam logic signed [10:0] C_GRAVITY    = 11'(GRAVITY);
    localparam logic signed [10:0] C_VEL_MAX    = 11'(VEL_MAX);
    localparam logic signed [9:0]  C_FLAP_VEL   = 10'(FLAP_VEL);
    localparam logic [13:0]        C_Y_START_FP = 14'(Y_START * 16);
    localparam logic signed [14:0] C_Y_MIN_FP   = 15'(Y_MIN * 16);
    localparam logic signed [14:0] C_Y_MAX_FP   = 15'(Y_MAX * 16);
    localparam logic [13:0]        C_Y_MIN_FP14 = 14'(Y_MIN * 16);
    localparam logic [13:0]        C_Y_MAX_FP14 = 14'(Y_MAX * 16);
    localparam logic [2:0]         C_REG_Y_LO   = 3'(REG_Y_LO);
    localparam logic [2:0]         C_REG_Y_HI   = 3'(REG_Y_HI);

    logic [1:0]        state_q,           state_d;
    logic [13:0]       y_fp_q,            y_fp_d;
    logic signed [9:0] vel_q,             vel_d;
    logic              dead_q,            dead_d;
    logic              flap_q;
    logic              flap_pending_q,    flap_pending_d;
    logic              restart_pending_q, restart_pending_d;
    logic              av_cs_q,           av_cs_d;
    logic              av_wr_q,           av_wr_d;
    logic [2:0]        av_addr_q,         av_addr_d;
    logic [7:0]        av_data_q,         av_data_d;
    logic              update_done_q,     update_done_d;
    logic              overrun_q,         overrun_d;

    logic signed [10:0] w_vel_inc;
    logic signed [9:0]  w_vel_n;
    logic signed [14:0] w_y_n;
    logic               w_flap_rise;

    // Candidate velocity and position for this frame; wide enough that the
    // gravity sum and a negative step below the ceiling never wrap.
    always_comb begin
        w_vel_inc = $signed({vel_q[9], vel_q}) + C_GRAVITY;
        if (flap_pending_q) begin
            w_vel_n = C_FLAP_VEL;
        end else if (w_vel_inc > C_VEL_MAX) begin
            w_vel_n = C_VEL_MAX[9:0];
        end else begin
            w_vel_n = w_vel_inc[9:0];
        end
        w_y_n = $signed({1'b0, y_fp_q}) + $signed({{5{w_vel_n[9]}}, w_vel_n});
    end

    // Frame sequencer: restart / physics step / two-byte register write.
    always_comb begin
        state_d           = state_q;
        y_fp_d            = y_fp_q;
        vel_d             = vel_q;
        dead_d            = dead_q;
        flap_pending_d    = flap_pending_q;
        restart_pending_d = restart_pending_q;
        av_cs_d           = av_cs_q;
        av_wr_d           = av_wr_q;
        av_addr_d         = av_addr_q;
        av_data_d         = av_data_q;
        update_done_d     = 1'b0;
        overrun_d         = 1'b0;

        // A dead bird cannot flap; the edge is discarded rather than queued.
        w_flap_rise = flap && !flap_q && !dead_q;

        // Busy: ticks are lost (flagged), restarts wait for the bus to finish.
        if (state_q != C_ST_IDLE) begin
            if (frame_tick) begin
                overrun_d = 1'b1;
            end
            if (restart) begin
                restart_pending_d = 1'b1;
            end
        end

        case (state_q)
            C_ST_IDLE: begin
                if (restart || restart_pending_q) begin
                    y_fp_d            = C_Y_START_FP;
                    vel_d             = '0;
                    dead_d            = 1'b0;
                    flap_pending_d    = 1'b0;
                    restart_pending_d = 1'b0;
                    av_cs_d           = 1'b1;
                    av_wr_d           = 1'b1;
                    av_addr_d         = C_REG_Y_LO;
                    av_data_d         = C_Y_START_FP[11:4];
                    state_d           = C_ST_WR_LO;
                end else if (frame_tick && enable && !dead_q) begin
                    state_d = C_ST_UPDATE;
                end
            end
            C_ST_UPDATE: begin
                if (w_y_n < C_Y_MIN_FP) begin
                    y_fp_d = C_Y_MIN_FP14;
                    vel_d  = '0;
                end else if (w_y_n >= C_Y_MAX_FP) begin
                    y_fp_d = C_Y_MAX_FP14;
                    vel_d  = '0;
                    dead_d = 1'b1;
                end else begin
                    y_fp_d = w_y_n[13:0];
                    vel_d  = w_vel_n;
                end
                flap_pending_d = 1'b0;
                av_cs_d        = 1'b1;
                av_wr_d        = 1'b1;
                av_addr_d      = C_REG_Y_LO;
                av_data_d      = y_fp_d[11:4];
                state_d        = C_ST_WR_LO;
            end
            C_ST_WR_LO: begin
                if (!av_waitrequest) begin
                    av_addr_d = C_REG_Y_HI;
                    av_data_d = {6'b0, y_fp_q[13:12]};
                    state_d   = C_ST_WR_HI;
                end
            end
            C_ST_WR_HI: begin
                if (!av_waitrequest) begin
                    av_cs_d       = 1'b0;
                    av_wr_d       = 1'b0;
                    av_addr_d     = '0;
                    av_data_d     = '0;
                    update_done_d = 1'b1;
                    state_d       = C_ST_IDLE;
                end
            end
            default: begin
                state_d = C_ST_IDLE;
            end
        endcase

        // A fresh edge arriving as the old request is consumed is kept.
        if (w_flap_rise) begin
            flap_pending_d = 1'b1;
        end
    end

    // State and output registers; reset aborts any bus transfer at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q           <= C_ST_IDLE;
            y_fp_q            <= C_Y_START_FP;
            vel_q             <= '0;
            dead_q            <= 1'b0;
            flap_q            <= 1'b0;
            flap_pending_q    <= 1'b0;
            restart_pending_q <= 1'b0;
            av_cs_q           <= 1'b0;
            av_wr_q           <= 1'b0;
            av_addr_q         <= '0;
            av_data_q         <= '0;
            update_done_q     <= 1'b0;
            overrun_q         <= 1'b0;
        end else begin
            state_q           <= state_d;
            y_fp_q            <= y_fp_d;
            vel_q             <= vel_d;
            dead_q            <= dead_d;
            flap_q            <= flap;
            flap_pending_q    <= flap_pending_d;
            restart_pending_q <= restart_pending_d;
            av_cs_q           <= av_cs_d;
            av_wr_q           <= av_wr_d;
            av_addr_q         <= av_addr_d;
            av_data_q         <= av_data_d;
            update_done_q     <= update_done_d;
            overrun_q         <= overrun_d;
        end
    end

    assign av_chipselect = av_cs_q;
    assign av_write      = av_wr_q;
    assign av_address    = av_addr_q;
    assign av_writedata  = av_data_q;
    assign bird_y        = y_fp_q[13:4];
    assign bird_vel      = vel_q;
    assign dead          = dead_q;
    assign update_done   = update_done_q;
    assign overrun       = overrun_q;

endmodule
`default_nettype wire
